// File: rtl/charge_session_ctrl.sv
// Coin-charger session controller: keyed amount entry, conversion to seconds, 1 s countdown.
// Optional mid-session top-up is compiled in with `define CHARGE_SESSION_TOPUP_EN.
module charge_session_ctrl #(
  parameter int CLK_HZ       = 1000,
  parameter int MAX_AMOUNT   = 20,
  parameter int MAX_DIGITS   = 2,
  parameter int SEC_PER_UNIT = 2,
  parameter int AMT_W        = 5,
  parameter int TIME_W       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_pressed,
  input  logic [3:0]        key_value,
  input  logic              start,
  input  logic              cancel,
  output logic [AMT_W-1:0]  amount,
  output logic [TIME_W-1:0] remaining_time,
  output logic              timing,
  output logic              done
);

  localparam int PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DIG_W  = 3;
  // Wide enough for amount*10+9 and remaining_time plus a full top-up, no overflow.
  localparam int WIDE_W = AMT_W + TIME_W + 8;

  localparam logic [WIDE_W-1:0] MAX_AMT_W = WIDE_W'(MAX_AMOUNT);
  localparam logic [WIDE_W-1:0] MAX_TIM_W = WIDE_W'(MAX_AMOUNT * SEC_PER_UNIT);
  localparam logic [WIDE_W-1:0] SPU_W     = WIDE_W'(SEC_PER_UNIT);
  localparam logic [WIDE_W-1:0] TEN_W     = WIDE_W'(10);
  localparam logic [WIDE_W-1:0] ONE_W     = WIDE_W'(1);
  localparam logic [PRE_W-1:0]  PRE_TC    = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
  localparam logic [DIG_W-1:0]  DIG_MAX   = DIG_W'(MAX_DIGITS);
  localparam logic [DIG_W-1:0]  DIG_ONE   = DIG_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, CHARGE = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [DIG_W-1:0]   digits_r, digits_s;
  logic [PRE_W-1:0]   presc_r, presc_s;
  logic [WIDE_W-1:0]  amt_n_s, rt_n_s, key_w_s, amt_w_s, rt_w_s, acc_s;
  logic               key_ok_s, tick_s, timing_s, done_s;
`ifdef CHARGE_SESSION_TOPUP_EN
  logic [WIDE_W-1:0]  add_s;
`endif

  function automatic logic [WIDE_W-1:0] sat(input logic [WIDE_W-1:0] a,
                                            input logic [WIDE_W-1:0] cap);
    sat = (a > cap) ? cap : a;
  endfunction

  assign key_ok_s = key_pressed & (key_value <= 4'd9);
  assign key_w_s  = WIDE_W'(key_value);
  assign amt_w_s  = WIDE_W'(amount);
  assign rt_w_s   = WIDE_W'(remaining_time);
  assign acc_s    = amt_w_s * TEN_W + key_w_s;
  assign tick_s   = (presc_r == PRE_TC);

  // Next-state and next-output computation for the session FSM.
  always_comb begin
    state_s  = state_r;
    amt_n_s  = amt_w_s;
    rt_n_s   = rt_w_s;
    digits_s = digits_r;
    presc_s  = presc_r;
    timing_s = timing;
    done_s   = 1'b0;
`ifdef CHARGE_SESSION_TOPUP_EN
    add_s    = '0;
`endif
    case (state_r)
      IDLE: begin
        if (cancel) begin
          state_s = IDLE;
        end else if (key_ok_s) begin
          amt_n_s  = sat(key_w_s, MAX_AMT_W);
          rt_n_s   = amt_n_s * SPU_W;
          digits_s = DIG_ONE;
          state_s  = ENTRY;
        end else begin
          state_s = IDLE;
        end
      end
      ENTRY: begin
        if (cancel || (start && (amt_w_s == '0))) begin
          state_s  = IDLE;
          amt_n_s  = '0;
          rt_n_s   = '0;
          digits_s = '0;
        end else if (start) begin
          state_s  = CHARGE;
          presc_s  = '0;
          timing_s = 1'b1;
        end else if (key_ok_s && (digits_r < DIG_MAX)) begin
          amt_n_s  = sat(acc_s, MAX_AMT_W);
          rt_n_s   = amt_n_s * SPU_W;
          digits_s = digits_r + DIG_ONE;
        end else begin
          state_s = ENTRY;
        end
      end
      CHARGE: begin
        presc_s = tick_s ? '0 : (presc_r + PRE_ONE);
        rt_n_s  = tick_s ? (rt_w_s - ONE_W) : rt_w_s;
`ifdef CHARGE_SESSION_TOPUP_EN
        if (key_ok_s) begin
          add_s   = sat(key_w_s, MAX_AMT_W - amt_w_s);
          amt_n_s = amt_w_s + add_s;
          rt_n_s  = sat(rt_w_s + add_s * SPU_W - (tick_s ? ONE_W : '0), MAX_TIM_W);
        end else begin
          amt_n_s = amt_w_s;
        end
`endif
        if (cancel || (rt_n_s == '0)) begin
          done_s   = ~cancel;
          state_s  = IDLE;
          amt_n_s  = '0;
          rt_n_s   = '0;
          digits_s = '0;
          presc_s  = '0;
          timing_s = 1'b0;
        end else begin
          state_s = CHARGE;
        end
      end
      default: begin
        state_s  = IDLE;
        amt_n_s  = '0;
        rt_n_s   = '0;
        digits_s = '0;
        presc_s  = '0;
        timing_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; rst_n is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r        <= IDLE;
      digits_r       <= '0;
      presc_r        <= '0;
      amount         <= '0;
      remaining_time <= '0;
      timing         <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_r        <= state_s;
      digits_r       <= digits_s;
      presc_r        <= presc_s;
      amount         <= amt_n_s[AMT_W-1:0];
      remaining_time <= rt_n_s[TIME_W-1:0];
      timing         <= timing_s;
      done           <= done_s;
    end
  end

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Self-checking bench for charge_session_ctrl (CLK_HZ=10): session model with an end-time
// view of the countdown, per-cycle compare, and directed literal checks.
module tb_charge_session_ctrl;
  localparam int C    = 10;
  localparam int MAXA = 20;
  localparam int MAXD = 2;
  localparam int SPU  = 2;
  localparam int MAXT = MAXA * SPU;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_pressed = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic [4:0] amount;
  logic [5:0] remaining_time;
  logic       timing, done;

  charge_session_ctrl #(.CLK_HZ(C)) dut (
    .clk(clk), .rst_n(rst_n), .key_pressed(key_pressed), .key_value(key_value),
    .start(start), .cancel(cancel), .amount(amount), .remaining_time(remaining_time),
    .timing(timing), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle / 1 entry / 2 charging; a session ends when k (cycles since
  // start accept) reaches len; remaining seconds are ceil((len-k)/C).
  int m_mode, m_amt, m_rem, m_dig, m_timing, m_done, m_k, m_len, m_add;
  bit m_on = 1'b0;

  task automatic m_clear();
    m_mode = 0; m_amt = 0; m_rem = 0; m_dig = 0; m_timing = 0; m_k = 0; m_len = 0;
  endtask

  always @(posedge clk) begin
    m_done = 0;
    if (rst_n) begin
      m_clear();
      m_on = 1'b1;
    end else if (m_mode == 2) begin
      if (cancel) m_clear();
      else begin
        m_k++;
`ifdef CHARGE_SESSION_TOPUP_EN
        if (key_pressed && key_value <= 9) begin
          m_add = (int'(key_value) < MAXA - m_amt) ? int'(key_value) : MAXA - m_amt;
          m_amt += m_add;
          m_len += m_add * SPU * C;
          if ((m_len - m_k + C - 1) / C > MAXT) m_len -= ((m_len - m_k + C - 1) / C - MAXT) * C;
        end
`endif
        if (m_k >= m_len) begin
          m_clear();
          m_done = 1;
        end else m_rem = (m_len - m_k + C - 1) / C;
      end
    end else if (m_mode == 1) begin
      if (cancel) m_clear();
      else if (start) begin
        if (m_amt > 0) begin
          m_mode = 2; m_timing = 1; m_k = 0; m_len = m_amt * SPU * C;
        end else m_clear();
      end else if (key_pressed && key_value <= 9 && m_dig < MAXD) begin
        m_amt = m_amt * 10 + int'(key_value);
        if (m_amt > MAXA) m_amt = MAXA;
        m_rem = m_amt * SPU;
        m_dig++;
      end
    end else begin
      if (!cancel && key_pressed && key_value <= 9) begin
        m_amt = (int'(key_value) > MAXA) ? MAXA : int'(key_value);
        m_rem = m_amt * SPU; m_dig = 1; m_mode = 1;
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) n_done_seen++;
    if (m_on) begin
      check("amount", 32'(amount), 32'(m_amt));
      check("remaining_time", 32'(remaining_time), 32'(m_rem));
      check("timing", 32'(timing), 32'(m_timing));
      check("done", 32'(done), 32'(m_done));
    end
  end

  task automatic drive(input bit kp, input logic [3:0] v, input bit st, input bit cn);
    key_pressed = kp; key_value = v; start = st; cancel = cn;
    @(negedge clk);
    key_pressed = 1'b0; key_value = 4'd0; start = 1'b0; cancel = 1'b0;
  endtask

  task automatic key(input logic [3:0] v);
    drive(1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input string name, input int exp_len);
    int cyc;
    cyc = -1;
    for (int i = 1; i <= exp_len + 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check(name, 32'(cyc), 32'(exp_len));
  endtask

  task automatic check_zero(input string name);
    check({name, "_amount"}, 32'(amount), 32'd0);
    check({name, "_time"}, 32'(remaining_time), 32'd0);
    check({name, "_timing"}, 32'(timing), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
  endtask

  int seen0;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    check_zero("reset");

    // Normal session: 15 units -> 30 s -> 300 cycles.
    key(4'd1); key(4'd5);
    check("entry15_amount", 32'(amount), 32'd15);
    check("entry15_time", 32'(remaining_time), 32'd30);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("start_timing", 32'(timing), 32'd1);
    wait_done("session15_len", 300);
    check("expiry_amount", 32'(amount), 32'd0);
    check("expiry_timing", 32'(timing), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // Saturation and digit limit.
    key(4'd9); key(4'd9);
    check("sat_amount", 32'(amount), 32'd20);
    check("sat_time", 32'(remaining_time), 32'd40);
    key(4'd3);
    check("digit_limit_amount", 32'(amount), 32'd20);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check_zero("entry_cancel");

    // Zero amount start returns to idle; start beats a simultaneous key.
    key(4'd0); drive(1'b0, 4'd0, 1'b1, 1'b0);
    check("zero_start_timing", 32'(timing), 32'd0);
    key(4'd3); drive(1'b1, 4'd4, 1'b1, 1'b0);
    check("start_wins_amount", 32'(amount), 32'd3);
    check("start_wins_time", 32'(remaining_time), 32'd6);
    check("start_wins_timing", 32'(timing), 32'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b1);

    // Cancel on cycle 55 of a session: no done afterwards.
    key(4'd7); drive(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (54) @(negedge clk);
    check("pre_cancel_time", 32'(remaining_time), 32'd9);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check_zero("charge_cancel");
    seen0 = n_done_seen;
    repeat (200) @(negedge clk);
    check("no_done_after_cancel", 32'(n_done_seen), 32'(seen0));

    // Reset mid-session (a key during charge is exercised too).
    key(4'd7); drive(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
`ifndef CHARGE_SESSION_TOPUP_EN
    key(4'd3);
    check("charge_key_ignored", 32'(amount), 32'd7);
`endif
    rst_n = 1'b1; @(negedge clk); rst_n = 1'b0;
    check_zero("mid_reset");
    seen0 = n_done_seen;
    repeat (200) @(negedge clk);
    check("no_done_after_reset", 32'(n_done_seen), 32'(seen0));

    // Out-of-range key in idle is ignored; short session length.
    key(4'd12);
    check("bad_key_amount", 32'(amount), 32'd0);
    key(4'd2);
    check("after_bad_key_amount", 32'(amount), 32'd2);
    check("after_bad_key_time", 32'(remaining_time), 32'd4);
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    wait_done("session2_len", 40);

`ifdef CHARGE_SESSION_TOPUP_EN
    // Top-up at cycle 25: 8 s left + 9 units.
    @(negedge clk);
    key(4'd5); drive(1'b0, 4'd0, 1'b1, 1'b0);
    repeat (24) @(negedge clk);
    key(4'd9);
    check("topup_amount", 32'(amount), 32'd14);
    check("topup_time", 32'(remaining_time), 32'd26);
    key(4'd9);
    check("topup_cap_amount", 32'(amount), 32'd20);
    check("topup_cap_time", 32'(remaining_time), 32'd38);
    drive(1'b0, 4'd0, 1'b0, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
